// File: rtl/counter_reset_generator.sv
// Periodic counter_reset pulse source: programmable period, high time and pulse count.
// Config is latched on start; all outputs are registered and reset synchronously.
module counter_reset_generator #(
   parameter int unsigned COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic [COUNTER_WIDTH-1:0] period,
   input  logic [COUNTER_WIDTH-1:0] pulse_width,
   input  logic [COUNTER_WIDTH-1:0] num_pulses,
   output logic                     counter_reset,
   output logic                     running,
   output logic [COUNTER_WIDTH-1:0] pulse_count,
   output logic [COUNTER_WIDTH-1:0] phase_counter
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                   r_state, w_state_next;
   logic [COUNTER_WIDTH-1:0] r_period_l, w_period_next;
   logic [COUNTER_WIDTH-1:0] r_width_l, w_width_next;
   logic [COUNTER_WIDTH-1:0] r_num_l, w_num_next;
   logic [COUNTER_WIDTH-1:0] r_phase, w_phase_next;
   logic [COUNTER_WIDTH-1:0] r_count, w_count_next;
   logic                     r_pulse, w_pulse_next;

   logic [COUNTER_WIDTH-1:0] w_period_clamped;
   logic [COUNTER_WIDTH-1:0] w_width_min1;
   logic [COUNTER_WIDTH-1:0] w_width_clamped;

   // Clamp so every period has at least one high and one low cycle.
   always_comb begin
      w_period_clamped = (period < COUNTER_WIDTH'(2)) ? COUNTER_WIDTH'(2) : period;
      w_width_min1     = (pulse_width == '0) ? COUNTER_WIDTH'(1) : pulse_width;
      w_width_clamped  = (w_width_min1 >= w_period_clamped) ?
                         (w_period_clamped - COUNTER_WIDTH'(1)) : w_width_min1;
   end

   always_comb begin
      w_state_next  = r_state;
      w_period_next = r_period_l;
      w_width_next  = r_width_l;
      w_num_next    = r_num_l;
      w_phase_next  = r_phase;
      w_count_next  = r_count;
      w_pulse_next  = 1'b0;

      if (stop) begin
         w_state_next = StIdle;
         w_phase_next = '0;
      end else if (start) begin
         w_state_next  = StRun;
         w_period_next = w_period_clamped;
         w_width_next  = w_width_clamped;
         w_num_next    = num_pulses;
         w_phase_next  = '0;
         w_count_next  = COUNTER_WIDTH'(1);
      end else if (r_state == StRun) begin
         if (r_phase >= r_period_l - COUNTER_WIDTH'(1)) begin
            w_phase_next = '0;
            if ((r_num_l != '0) && (r_count == r_num_l)) begin
               w_state_next = StIdle;
            end else if (r_count != '1) begin
               w_count_next = r_count + COUNTER_WIDTH'(1);
            end
         end else begin
            w_phase_next = r_phase + COUNTER_WIDTH'(1);
         end
      end

      // Registered pulse reflects the phase that becomes visible alongside it.
      w_pulse_next = (w_state_next == StRun) && (w_phase_next < w_width_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_period_l <= '0;
         r_width_l  <= '0;
         r_num_l    <= '0;
         r_phase    <= '0;
         r_count    <= '0;
         r_pulse    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_period_l <= w_period_next;
         r_width_l  <= w_width_next;
         r_num_l    <= w_num_next;
         r_phase    <= w_phase_next;
         r_count    <= w_count_next;
         r_pulse    <= w_pulse_next;
      end
   end

   assign counter_reset = r_pulse;
   assign running       = (r_state == StRun);
   assign pulse_count   = r_count;
   assign phase_counter = r_phase;

endmodule

// File: doc/counter_reset_generator.md
Name: counter_reset_generator

Overview:
Generates the periodic counter_reset pulse stream that the counter-delayed trigger consumes. The generator is the source end of that interface, while the trigger measures periods from the stream. It produces pulses with a programmable period and width, for a programmable count or continuously. It sits in the PL clock domain next to the trigger logic and is driven by a start/stop pulse pair from the register bank.

Parameters:
COUNTER_WIDTH, 32, width of period, pulse_width, num_pulses, pulse_count and phase_counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; latches config and starts/restarts generation.
stop  input  1  single-cycle pulse; halts generation.
period  input  COUNTER_WIDTH  pulse period in clk cycles.
pulse_width  input  COUNTER_WIDTH  high time of counter_reset in clk cycles.
num_pulses  input  COUNTER_WIDTH  pulses to emit; 0 = continuous.
counter_reset  output  1  generated pulse stream (registered).
running  output  1  high while the generator is in RUN.
pulse_count  output  COUNTER_WIDTH  pulses emitted since last start.
phase_counter  output  COUNTER_WIDTH  position within current period, 0..period_l-1.

Behaviour:
- reset (synchronous, active-high): state=IDLE; counter_reset=0, running=0, pulse_count=0, phase_counter=0; latched config=0. reset overrides start/stop.
- States: IDLE, RUN.
- IDLE: counter_reset=0, running=0; phase_counter=0; pulse_count holds its last value.
- On start (sampled at edge k): latch period_l, width_l, num_l; phase_counter=0; pulse_count=1; state=RUN. At edge k+1 outputs show counter_reset=1 and running=1, so latency is 1 cycle.
- Latch clamping: period_l=max(period,2); width_l=max(pulse_width,1); if width_l>=period_l then width_l=period_l-1. Result: at least 1 low cycle per period.
- RUN, each cycle:
  - counter_reset=1 iff phase_counter<width_l.
  - phase_counter increments each cycle and wraps from period_l-1 to 0.
  - On wrap: if num_l!=0 and pulse_count==num_l, go to IDLE; counter_reset stays 0 and no new pulse starts. Otherwise pulse_count increments, saturating at 2^COUNTER_WIDTH-1, and a new pulse begins.
- Config inputs are ignored while in RUN; they take effect only on the next start.
- stop in RUN: at next edge state=IDLE and counter_reset=0, including mid-pulse (the pulse is truncated). pulse_count holds.
- start while in RUN: full restart with a fresh latch; phase_counter=0, pulse_count=1, and counter_reset is high next cycle. An in-flight pulse merges into the new one with no low gap.
- start and stop in the same cycle: stop wins; result is IDLE.
- stop while in IDLE: no effect.
- num_pulses=0: runs until stop or reset; pulse_count saturates and does not wrap.

Test Plan:
- reset=1 for 5 cycles, then start with period=250, pulse_width=10, num_pulses=0 -> counter_reset high for cycles 1..10 and 251..260 after start; pulse_count=1, then 2 at cycle 251; running=1 throughout.
- period=100, pulse_width=20, num_pulses=3, start -> exactly 3 pulses (cycles 1-20, 101-120, 201-220); running falls at cycle 301; pulse_count stays 3; counter_reset stays 0.
- Continuous run with period=50, width=25; stop at phase_counter=10 -> counter_reset=0 and running=0 on the next cycle; pulse_count holds; a later start restarts with pulse_count=1.
- Clamping: period=1, width=5 -> alternating 1,0,1,0; period=10, width=0 -> width 1; period=10, width=12 -> width 9 (high 9, low 1).
- start and stop asserted together in IDLE and in RUN -> IDLE, no pulse emitted. start mid-pulse in RUN with a new period=30 -> counter_reset stays high, phase_counter=0, and the new period takes effect.
- reset asserted mid-pulse in RUN -> all outputs 0 next cycle; start held during reset is ignored; start after reset behaves as in scenario 1.
